// File: rtl/multi_ch_prescaler.sv
// NUM_CH shadow-buffered programmable dividers; defining PSC_PHASE_EN adds a per-channel restart phase.
// out/tick/busy are registered one cycle behind cnt; register writes are always accepted (no backpressure).
module multi_ch_prescaler #(
   parameter int NUM_CH     = 4,
   parameter int DATA_WIDTH = 8,
   parameter int CH_W       = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_CH-1:0]     en,
   input  logic                  sync,
   input  logic                  wr_en,
   input  logic [CH_W-1:0]       wr_ch,
   input  logic [1:0]            wr_sel,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [NUM_CH-1:0]     out,
   output logic [NUM_CH-1:0]     tick,
   output logic [NUM_CH-1:0]     busy
);

   localparam logic [1:0]            MODE_ONESHOT = 2'd1;
   localparam logic [1:0]            MODE_PULSE   = 2'd2;
   localparam logic [DATA_WIDTH-1:0] ONE          = DATA_WIDTH'(1);

   logic [DATA_WIDTH-1:0] p_s_q [NUM_CH];
   logic [DATA_WIDTH-1:0] p_s_d [NUM_CH];
   logic [DATA_WIDTH-1:0] h_s_q [NUM_CH];
   logic [DATA_WIDTH-1:0] h_s_d [NUM_CH];
   logic [1:0]            m_s_q [NUM_CH];
   logic [1:0]            m_s_d [NUM_CH];
   logic [DATA_WIDTH-1:0] p_a_q [NUM_CH];
   logic [DATA_WIDTH-1:0] p_a_d [NUM_CH];
   logic [DATA_WIDTH-1:0] h_a_q [NUM_CH];
   logic [DATA_WIDTH-1:0] h_a_d [NUM_CH];
   logic [1:0]            m_a_q [NUM_CH];
   logic [1:0]            m_a_d [NUM_CH];
   logic [DATA_WIDTH-1:0] cnt_q [NUM_CH];
   logic [DATA_WIDTH-1:0] cnt_d [NUM_CH];
   logic [DATA_WIDTH-1:0] load_c [NUM_CH];
`ifdef PSC_PHASE_EN
   logic [DATA_WIDTH-1:0] ph_s_q [NUM_CH];
   logic [DATA_WIDTH-1:0] ph_s_d [NUM_CH];
   logic [DATA_WIDTH-1:0] ph_a_q [NUM_CH];
   logic [DATA_WIDTH-1:0] ph_a_d [NUM_CH];
`endif

   logic [NUM_CH-1:0] done_q, done_d;
   logic [NUM_CH-1:0] out_q, out_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] busy_q, busy_d;
   logic [NUM_CH-1:0] run_c, term_c;

`ifdef PSC_PHASE_EN
   // Restart value from the registers about to become active; out-of-range phase clamps to the last count.
   function automatic logic [DATA_WIDTH-1:0] phase_load(input logic [DATA_WIDTH-1:0] p,
                                                        input logic [DATA_WIDTH-1:0] ph);
      if (p == '0) begin
         return '0;
      end else if (ph >= p) begin
         return p - ONE;
      end else begin
         return ph;
      end
   endfunction
`endif

   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         p_s_d[i]  = p_s_q[i];
         h_s_d[i]  = h_s_q[i];
         m_s_d[i]  = m_s_q[i];
         p_a_d[i]  = p_a_q[i];
         h_a_d[i]  = h_a_q[i];
         m_a_d[i]  = m_a_q[i];
         cnt_d[i]  = cnt_q[i];
         done_d[i] = done_q[i];
         out_d[i]  = 1'b0;
         tick_d[i] = 1'b0;
`ifdef PSC_PHASE_EN
         ph_s_d[i]  = ph_s_q[i];
         ph_a_d[i]  = ph_a_q[i];
         load_c[i]  = phase_load(p_s_q[i], ph_s_q[i]);
`else
         load_c[i]  = '0;
`endif
         run_c[i]  = en[i] && (p_a_q[i] != '0) && !done_q[i];
         term_c[i] = run_c[i] && (cnt_q[i] == p_a_q[i] - ONE);
         busy_d[i] = run_c[i];

         if (run_c[i]) begin
            tick_d[i] = term_c[i] && !sync;
            out_d[i]  = (m_a_q[i] == MODE_PULSE) ? (term_c[i] && !sync) : (cnt_q[i] < h_a_q[i]);
            cnt_d[i]  = term_c[i] ? '0 : cnt_q[i] + ONE;
            if (term_c[i] && (m_a_q[i] == MODE_ONESHOT)) begin
               done_d[i] = 1'b1;
            end
         end

         // Disabled channels preload their restart count so the first enabled cycle starts in phase.
         if (!en[i] || sync) begin
            cnt_d[i]  = load_c[i];
            done_d[i] = 1'b0;
         end

         if (!en[i] || sync || term_c[i]) begin
            p_a_d[i] = p_s_q[i];
            h_a_d[i] = h_s_q[i];
            m_a_d[i] = m_s_q[i];
`ifdef PSC_PHASE_EN
            ph_a_d[i] = ph_s_q[i];
`endif
         end

         // Out-of-range wr_ch never matches a channel index, so such writes fall away.
         if (wr_en && (int'(wr_ch) == i)) begin
            case (wr_sel)
               2'd0: p_s_d[i] = wr_data;
               2'd1: h_s_d[i] = wr_data;
               2'd2: m_s_d[i] = wr_data[1:0];
               default: begin
`ifdef PSC_PHASE_EN
                  ph_s_d[i] = wr_data;
`endif
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            p_s_q[i] <= '0;
            h_s_q[i] <= '0;
            m_s_q[i] <= '0;
            p_a_q[i] <= '0;
            h_a_q[i] <= '0;
            m_a_q[i] <= '0;
            cnt_q[i] <= '0;
`ifdef PSC_PHASE_EN
            ph_s_q[i] <= '0;
            ph_a_q[i] <= '0;
`endif
         end
         done_q <= '0;
         out_q  <= '0;
         tick_q <= '0;
         busy_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            p_s_q[i] <= p_s_d[i];
            h_s_q[i] <= h_s_d[i];
            m_s_q[i] <= m_s_d[i];
            p_a_q[i] <= p_a_d[i];
            h_a_q[i] <= h_a_d[i];
            m_a_q[i] <= m_a_d[i];
            cnt_q[i] <= cnt_d[i];
`ifdef PSC_PHASE_EN
            ph_s_q[i] <= ph_s_d[i];
            ph_a_q[i] <= ph_a_d[i];
`endif
         end
         done_q <= done_d;
         out_q  <= out_d;
         tick_q <= tick_d;
         busy_q <= busy_d;
      end
   end

   assign out  = out_q;
   assign tick = tick_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_multi_ch_prescaler.sv
// Scoreboard bench for multi_ch_prescaler: directed scenarios plus randomized writes/enables/syncs.
module tb_multi_ch_prescaler;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] en;
   logic       sync;
   logic       wr_en;
   logic [2:0] wr_ch;
   logic [1:0] wr_sel;
   logic [7:0] wr_data;
   logic [3:0] out, tick, busy;

   multi_ch_prescaler #(.NUM_CH(4), .DATA_WIDTH(8), .CH_W(3)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
      .wr_sel(wr_sel), .wr_data(wr_data), .out(out), .tick(tick), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] o;
      logic [3:0] t;
      logic [3:0] b;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] act_out_q[$];
   logic [3:0] act_tick_q[$];
   logic [3:0] act_busy_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cycle_n = 0;

   // Reference model: shadow/active/count/done per channel, as plain integers.
   int m_ps[4], m_hs[4], m_ms[4], m_phs[4];
   int m_pa[4], m_ha[4], m_ma[4], m_pha[4];
   int m_cnt[4];
   bit m_done[4];

   task automatic model_reset();
      for (int c = 0; c < 4; c++) begin
         m_ps[c] = 0; m_hs[c] = 0; m_ms[c] = 0; m_phs[c] = 0;
         m_pa[c] = 0; m_ha[c] = 0; m_ma[c] = 0; m_pha[c] = 0;
         m_cnt[c] = 0; m_done[c] = 0;
      end
      exp_q.delete();
   endtask

   function automatic int restart_count(int c);
`ifdef PSC_PHASE_EN
      if (m_pa[c] == 0) return 0;
      if (m_pha[c] >= m_pa[c]) return m_pa[c] - 1;
      return m_pha[c];
`else
      return 0 * c;
`endif
   endfunction

   // Advance the model by one clock using the inputs currently driven; push what the DUT must show after it.
   task automatic model_step();
      exp_t e;
      e.o = '0; e.t = '0; e.b = '0;
      for (int c = 0; c < 4; c++) begin
         bit counting, fin, shot_end;
         counting = en[c] && (m_pa[c] != 0) && !m_done[c];
         fin      = counting && (m_cnt[c] == m_pa[c] - 1);
         shot_end = fin && (m_ma[c] == 1);
         if (counting) begin
            e.b[c] = 1'b1;
            e.t[c] = fin && !sync;
            e.o[c] = (m_ma[c] == 2) ? (fin && !sync) : (m_cnt[c] < m_ha[c]);
         end
         if (!en[c] || sync || fin) begin
            m_pa[c] = m_ps[c]; m_ha[c] = m_hs[c]; m_ma[c] = m_ms[c]; m_pha[c] = m_phs[c];
         end
         if (!en[c] || sync) begin
            m_cnt[c]  = restart_count(c);
            m_done[c] = 0;
         end else if (fin) begin
            m_cnt[c] = 0;
            if (shot_end) m_done[c] = 1;
         end else if (counting) begin
            m_cnt[c] = m_cnt[c] + 1;
         end
      end
      if (wr_en && int'(wr_ch) < 4) begin
         case (wr_sel)
            2'd0: m_ps[wr_ch] = int'(wr_data);
            2'd1: m_hs[wr_ch] = int'(wr_data);
            2'd2: m_ms[wr_ch] = int'(wr_data) & 3;
            default: begin
`ifdef PSC_PHASE_EN
               m_phs[wr_ch] = int'(wr_data);
`endif
            end
         endcase
      end
      exp_q.push_back(e);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic cyc(input logic [3:0] e, input logic s, input logic we, input logic [2:0] wc,
                      input logic [1:0] ws, input logic [7:0] wd);
      @(negedge clk);
      en = e; sync = s; wr_en = we; wr_ch = wc; wr_sel = ws; wr_data = wd;
      model_step();
   endtask

   task automatic wr(input logic [3:0] e, input logic [2:0] wc, input logic [1:0] ws, input logic [7:0] wd);
      cyc(e, 1'b0, 1'b1, wc, ws, wd);
   endtask

   task automatic idle(input logic [3:0] e, input int n);
      for (int k = 0; k < n; k++) cyc(e, 1'b0, 1'b0, 3'd0, 2'd0, 8'd0);
   endtask

   task automatic clear_hist();
      act_out_q.delete();
      act_tick_q.delete();
      act_busy_q.delete();
   endtask

   // Monitor: every output sample after an edge is matched against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         cycle_n++;
         if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if ({out, tick, busy} !== {e.o, e.t, e.b}) begin
               errors++;
               $display("FAIL sb cycle %0d: out=%b tick=%b busy=%b, required out=%b tick=%b busy=%b",
                        cycle_n, out, tick, busy, e.o, e.t, e.b);
            end
            act_out_q.push_back(out);
            act_tick_q.push_back(tick);
            act_busy_q.push_back(busy);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [11:0] pat_o, pat_t;
      logic [3:0]  en_r;
      logic        s_r, we_r;
      logic [2:0]  wc_r;
      logic [1:0]  ws_r;
      logic [7:0]  wd_r;
      int          n_tick, n_out, n_busy;

      rst_n = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
      model_reset();
      #2 rst_n = 1'b0;
      #3;
      chk("reset_out", out, 0);
      chk("reset_tick", tick, 0);
      chk("reset_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // DIV: ch0 P=6 H=2
      wr(4'h0, 3'd0, 2'd0, 8'd6);
      wr(4'h0, 3'd0, 2'd1, 8'd2);
      wr(4'h0, 3'd0, 2'd2, 8'd0);
      idle(4'h0, 1);
      idle(4'h1, 1);
      clear_hist();
      idle(4'h1, 11);
      @(posedge clk); #2;
      pat_o = 12'b110000110000;
      pat_t = 12'b000001000001;
      chk("div_samples", act_out_q.size(), 12);
      for (int k = 0; k < 12 && k < act_out_q.size(); k++) begin
         chk($sformatf("div_out[%0d]", k), act_out_q[k][0], pat_o[11-k]);
         chk($sformatf("div_tick[%0d]", k), act_tick_q[k][0], pat_t[11-k]);
      end

      // Reset between edges while ch0 runs
      @(posedge clk); #2;
      chk("prerst_busy0", busy[0], 1);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_out", out, 0);
      chk("midrst_tick", tick, 0);
      chk("midrst_busy", busy, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(4'hF, 4);

      // Shadow update: ch1 P=4 H=2, rewrite P=8 H=4 at cnt=1
      wr(4'h0, 3'd1, 2'd0, 8'd4);
      wr(4'h0, 3'd1, 2'd1, 8'd2);
      idle(4'h0, 1);
      idle(4'h2, 1);
      wr(4'h2, 3'd1, 2'd0, 8'd8);
      wr(4'h2, 3'd1, 2'd1, 8'd4);
      idle(4'h2, 20);

      // ONESHOT: ch2 P=5 H=5
      wr(4'h2, 3'd2, 2'd0, 8'd5);
      wr(4'h2, 3'd2, 2'd1, 8'd5);
      wr(4'h2, 3'd2, 2'd2, 8'd1);
      idle(4'h2, 1);
      idle(4'h6, 1);
      clear_hist();
      idle(4'h6, 11);
      @(posedge clk); #2;
      n_tick = 0; n_out = 0; n_busy = 0;
      for (int k = 0; k < act_out_q.size(); k++) begin
         n_tick += int'(act_tick_q[k][2]);
         n_out  += int'(act_out_q[k][2]);
         n_busy += int'(act_busy_q[k][2]);
      end
      chk("oneshot_ticks", n_tick, 1);
      chk("oneshot_out_high", n_out, 5);
      chk("oneshot_busy_high", n_busy, 5);
      cyc(4'h6, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
      idle(4'h6, 10);

      // Boundaries on ch3: P=1 H=1, then H=0, then P=0, then out-of-range channel writes
      wr(4'h6, 3'd3, 2'd0, 8'd1);
      wr(4'h6, 3'd3, 2'd1, 8'd1);
      idle(4'h6, 1);
      idle(4'hE, 5);
      wr(4'hE, 3'd3, 2'd1, 8'd0);
      idle(4'hE, 5);
      wr(4'hE, 3'd3, 2'd0, 8'd0);
      idle(4'hE, 4);
      wr(4'hE, 3'd5, 2'd0, 8'd3);
      wr(4'hE, 3'd7, 2'd2, 8'd2);
      idle(4'hE, 6);

      // sync alignment: ch0 P=4, ch3 P=8 started out of phase
      wr(4'h0, 3'd0, 2'd0, 8'd4);
      wr(4'h0, 3'd0, 2'd1, 8'd2);
      wr(4'h0, 3'd0, 2'd2, 8'd0);
      wr(4'h0, 3'd3, 2'd0, 8'd8);
      wr(4'h0, 3'd3, 2'd1, 8'd4);
      wr(4'h0, 3'd3, 2'd2, 8'd0);
      idle(4'h0, 1);
      idle(4'h1, 2);
      idle(4'h9, 5);
      cyc(4'h9, 1'b1, 1'b0, 3'd0, 2'd0, 8'd0);
      idle(4'h9, 16);

      // Randomized traffic
      en_r = 4'hF;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 15) == 0) en_r = 4'($urandom_range(0, 15));
         s_r  = ($urandom_range(0, 39) == 0);
         we_r = ($urandom_range(0, 3) == 0);
         wc_r = 3'($urandom_range(0, 7));
         ws_r = 2'($urandom_range(0, 3));
         wd_r = (ws_r == 2'd2) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 10));
         cyc(en_r, s_r, we_r, wc_r, ws_r, wd_r);
      end

      @(posedge clk); #2;
      chk("sb_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
